audio_frame_sched: RTL and testbench

Schedules stereo audio frames into the PWM stereo output stage at the audio sample rate. It generates the sample-rate tick from the 100 MHz clock and buffers producer frames in an internal FIFO. On each tick it pops one frame and holds it stable on the sample outputs that drive the PWM block. It also primes the buffer before playback, substitutes silence on underrun, and counts underruns for software.

---
 rtl/audio_frame_sched_if.sv | 30 +++
 rtl/audio_frame_sched.sv | 127 ++++++++++++
 tb/tb_audio_frame_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/audio_frame_sched_if.sv
// Frame push, sample output and status signals between a producer/PWM side and
// the audio frame scheduler; master drives the scheduler inputs.
interface audio_frame_sched_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          enable_in;
  logic                          frame_valid_in;
  logic                          frame_ready_out;
  logic [7:0]                    frame_l_in;
  logic [7:0]                    frame_r_in;
  logic                          tick_out;
  logic [7:0]                    sample_l_out;
  logic [7:0]                    sample_r_out;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level_out;
  logic                          underrun_out;
  logic [15:0]                   underrun_count_out;
  logic                          clear_underrun_in;

  modport slave (
    input  enable_in, frame_valid_in, frame_l_in, frame_r_in, clear_underrun_in,
    output frame_ready_out, tick_out, sample_l_out, sample_r_out,
           fifo_level_out, underrun_out, underrun_count_out
  );

  modport master (
    output enable_in, frame_valid_in, frame_l_in, frame_r_in, clear_underrun_in,
    input  frame_ready_out, tick_out, sample_l_out, sample_r_out,
           fifo_level_out, underrun_out, underrun_count_out
  );
endinterface

// File: rtl/audio_frame_sched.sv
// Buffers stereo frames and releases one per sample tick to the PWM stage,
// priming before playback and substituting silence (signed 0) on underrun.
module audio_frame_sched #(
  parameter int CLK_DIV     = 2083,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  audio_frame_sched_if.slave   bus
);
  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              LW        = AW + 1;
  localparam logic [LW-1:0]   DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]   PRIME_L   = LW'(PRIME_LEVEL);
  localparam logic [15:0]     TICK_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic [7:0]      smp_l_q, smp_l_d, smp_r_q, smp_r_d;
  logic            und_q, und_d;
  logic [15:0]     und_cnt_q, und_cnt_d;
  logic [15:0]     mem [FIFO_DEPTH];
  logic            tick, push, pop;

  assign tick = (state_q != IDLE) && (cnt_q == TICK_LAST);
  // Gated by reset so every output reads 0 while reset is held.
  assign bus.frame_ready_out = rst_n_in && bus.enable_in && (lvl_q < DEPTH_L);
  assign push = bus.frame_valid_in && bus.frame_ready_out;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    lvl_d     = lvl_q;
    smp_l_d   = smp_l_q;
    smp_r_d   = smp_r_q;
    und_d     = 1'b0;
    und_cnt_d = und_cnt_q;
    pop       = 1'b0;

    if (!bus.enable_in) begin
      state_d  = IDLE;
      cnt_d    = 16'd0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      lvl_d    = '0;
      smp_l_d  = 8'd0;
      smp_r_d  = 8'd0;
    end else begin
      if (state_q == IDLE || tick) cnt_d = 16'd0;
      else                         cnt_d = cnt_q + 16'd1;

      case (state_q)
        IDLE:  state_d = PRIME;
        PRIME: if (lvl_q >= PRIME_L) state_d = PLAY;
        PLAY: begin
          if (tick) begin
            if (lvl_q != '0) begin
              pop     = 1'b1;
              smp_l_d = mem[rd_ptr_q][15:8];
              smp_r_d = mem[rd_ptr_q][7:0];
            end else begin
              // A frame pushed this same cycle is stored, never bypassed.
              smp_l_d = 8'd0;
              smp_r_d = 8'd0;
              und_d   = 1'b1;
              state_d = PRIME;
              if (und_cnt_q != 16'hFFFF) und_cnt_d = und_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   lvl_d = lvl_q + 1'b1;
        2'b01:   lvl_d = lvl_q - 1'b1;
        default: lvl_d = lvl_q;
      endcase
    end

    if (bus.clear_underrun_in) und_cnt_d = 16'd0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      lvl_q     <= '0;
      smp_l_q   <= 8'd0;
      smp_r_q   <= 8'd0;
      und_q     <= 1'b0;
      und_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      lvl_q     <= lvl_d;
      smp_l_q   <= smp_l_d;
      smp_r_q   <= smp_r_d;
      und_q     <= und_d;
      und_cnt_q <= und_cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr_q] <= {bus.frame_l_in, bus.frame_r_in};
  end

  assign bus.tick_out           = tick;
  assign bus.sample_l_out       = smp_l_q;
  assign bus.sample_r_out       = smp_r_q;
  assign bus.fifo_level_out     = lvl_q;
  assign bus.underrun_out       = und_q;
  assign bus.underrun_count_out = und_cnt_q;
endmodule

// File: tb/tb_audio_frame_sched.sv
// Drives audio_frame_sched with directed and random traffic, checking every
// output each cycle against a queue-based reference model.
module tb_audio_frame_sched;
  localparam int CLK_DIV = 8;
  localparam int DEPTH   = 16;
  localparam int PRIME   = 8;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  audio_frame_sched_if #(.FIFO_DEPTH(DEPTH)) bus ();

  audio_frame_sched #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PRIME)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .bus(bus.slave)
  );

  // Reference model: 0 idle, 1 priming, 2 playing; frames kept in a queue.
  int          m_state;
  logic [15:0] m_q[$];
  logic [7:0]  m_l, m_r;
  bit          m_und;
  int          m_cnt;
  int          m_phase;   // cycles spent outside idle since last leaving it
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_tick();
    return (m_state != 0) && ((m_phase % CLK_DIV) == CLK_DIV - 1);
  endfunction

  function automatic bit m_ready();
    return rst_n_in && bus.enable_in && (m_q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_state = 0; m_q.delete(); m_l = 0; m_r = 0; m_und = 0; m_cnt = 0; m_phase = 0;
  endtask

  task automatic check_all();
    chk("ready",  32'(bus.frame_ready_out),    32'(m_ready()));
    chk("tick",   32'(bus.tick_out),           32'(m_tick()));
    chk("smp_l",  32'(bus.sample_l_out),       32'(m_l));
    chk("smp_r",  32'(bus.sample_r_out),       32'(m_r));
    chk("level",  32'(bus.fifo_level_out),     32'(m_q.size()));
    chk("und",    32'(bus.underrun_out),       32'(m_und));
    chk("ucount", 32'(bus.underrun_count_out), 32'(m_cnt));
  endtask

  task automatic model_edge();
    bit t, push;
    t    = m_tick();
    push = bus.frame_valid_in && m_ready();
    m_und = 0;
    if (!bus.enable_in) begin
      m_state = 0; m_q.delete(); m_l = 0; m_r = 0; m_phase = 0;
    end else begin
      if (m_state != 0) m_phase++;
      if (m_state == 0) m_state = 1;
      else if (m_state == 1) begin
        if (m_q.size() >= PRIME) m_state = 2;
      end else if (t) begin
        if (m_q.size() > 0) begin
          {m_l, m_r} = m_q.pop_front();
        end else begin
          m_l = 0; m_r = 0; m_und = 1; m_state = 1;
        end
      end
      if (push) m_q.push_back({bus.frame_l_in, bus.frame_r_in});
    end
    if (bus.clear_underrun_in) m_cnt = 0;
    else if (m_und && m_cnt < 65535) m_cnt++;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic en, input logic v, input logic [7:0] l,
                     input logic [7:0] r, input logic clr);
    bus.enable_in = en; bus.frame_valid_in = v; bus.frame_l_in = l;
    bus.frame_r_in = r; bus.clear_underrun_in = clr;
    #1;
    check_all();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
  endtask

  initial begin
    int pv;
    bus.enable_in = 0; bus.frame_valid_in = 0; bus.frame_l_in = 0;
    bus.frame_r_in = 0; bus.clear_underrun_in = 0;
    model_reset();
    @(negedge clk_in); @(negedge clk_in);
    check_all();
    rst_n_in = 1'b1;

    // Enabled with no producer: ticks every CLK_DIV, silence, no underrun.
    for (int i = 0; i < 30; i++) cyc(1, 0, 8'd0, 8'd0, 0);

    // Three prime/drain rounds, each ending in exactly one underrun.
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int k = 1; k <= 8; k++) cyc(1, 1, 8'(k), 8'(-k), 0);
      for (int i = 0; i < 90; i++) cyc(1, 0, 8'd0, 8'd0, 0);
      chk("ucount_round", 32'(bus.underrun_count_out), 32'(rnd + 1));
    end
    cyc(1, 0, 8'd0, 8'd0, 1);
    chk("ucount_clear", 32'(bus.underrun_count_out), 32'd0);

    // Back-to-back pushes fill the FIFO while playback drains slowly.
    for (int i = 0; i < 60; i++) cyc(1, 1, 8'($urandom), 8'($urandom), 0);

    // Drain to a partial level, then disable mid-play and re-enable.
    for (int i = 0; i < 85; i++) cyc(1, 0, 8'd0, 8'd0, 0);
    cyc(0, 1, 8'h55, 8'hAA, 0);
    chk("flush_level", 32'(bus.fifo_level_out), 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'd0, 8'd0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 8'($urandom), 8'($urandom), 0);

    // Random traffic in segments of differing producer rate.
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: pv = 100; 1: pv = 20; 2: pv = 5; 3: pv = 60; 4: pv = 12; default: pv = 100;
      endcase
      for (int i = 0; i < 300; i++)
        cyc($urandom_range(0, 199) != 0, $urandom_range(0, 99) < pv,
            8'($urandom), 8'($urandom), $urandom_range(0, 63) == 0);
    end

    // Asynchronous reset between edges while playing.
    for (int i = 0; i < 40; i++) cyc(1, 1, 8'($urandom), 8'($urandom), 0);
    #2 rst_n_in = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_smp_l", 32'(bus.sample_l_out), 32'd0);
    @(negedge clk_in);
    bus.enable_in = 0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'd0, 8'd0, 0);
    for (int i = 0; i < 40; i++) cyc(1, $urandom_range(0, 1), 8'($urandom), 8'($urandom), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
